// File: rtl/fifo_rd_stream.sv
// Read-side engine for the dual-clock fifo: pops words via ren/empty/dat_i and re-presents them as a
// valid/ready stream through a 2-entry buffer. Optional burst control is built with FIFO_RD_BURST_EN.
module fifo_rd_stream #(
  parameter int DW    = 4,
  parameter int CNT_W = 8
) (
  input  logic             rclk,
  input  logic             rst_ni,
  input  logic             empty,
  input  logic [DW-1:0]    dat_i,
  output logic             ren,
  output logic [DW-1:0]    m_dat_o,
  output logic             m_vld_o,
  input  logic             m_rdy_i,
  output logic [CNT_W-1:0] cnt_o,
  input  logic             start_i,
  input  logic [CNT_W-1:0] burst_len_i,
  output logic             busy_o,
  output logic             done_o
);

  // Stream handshake: a word moves when m_vld_o & m_rdy_i are both high at a rising rclk; m_dat_o
  // and m_vld_o never change while m_vld_o=1 and m_rdy_i=0.

  logic [DW-1:0] buf0;
  logic [DW-1:0] buf1;
  logic [1:0]    occ;
  logic          infl;
  logic          allow;
  logic          pop;
  logic [1:0]    pend;
  logic          room;

  assign pop     = m_vld_o & m_rdy_i;
  assign m_vld_o = (occ != 2'd0);
  assign m_dat_o = buf0;

  // occ + infl never exceeds 2; a word leaving this cycle frees its slot for a new read.
  assign pend = occ + {1'b0, infl};
  assign room = (pend < 2'd2) | ((pend == 2'd2) & pop);
  assign ren  = ~empty & rst_ni & allow & room;

  always_ff @(posedge rclk or negedge rst_ni) begin
    if (!rst_ni) begin
      buf0  <= '0;
      buf1  <= '0;
      occ   <= 2'd0;
      infl  <= 1'b0;
      cnt_o <= '0;
    end else begin
      infl <= ren;
      if (pop) cnt_o <= cnt_o + 1'b1;
      case ({infl, pop})
        2'b10: begin
          if (occ == 2'd0) buf0 <= dat_i;
          else             buf1 <= dat_i;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          buf0 <= buf1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            buf0 <= dat_i;
          end else begin
            buf0 <= buf1;
            buf1 <= dat_i;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FIFO_RD_BURST_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_nxt;
  logic             done_nxt;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] issued_q;

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    allow     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_i) begin
          if (burst_len_i != '0) state_nxt = S_RUN;
          else                   done_nxt  = 1'b1;
        end
      end
      S_RUN: begin
        allow = (issued_q < len_q);
        if (ren && ((issued_q + ONE) == len_q)) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if ((occ == 2'd0) && !infl) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge rclk or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= S_IDLE;
      done_o   <= 1'b0;
      len_q    <= '0;
      issued_q <= '0;
    end else begin
      state  <= state_nxt;
      done_o <= done_nxt;
      if ((state == S_IDLE) && start_i && (burst_len_i != '0)) begin
        len_q    <= burst_len_i;
        issued_q <= '0;
      end else if (ren) begin
        issued_q <= issued_q + ONE;
      end
    end
  end

  assign busy_o = (state != S_IDLE);
`else
  logic unused_burst_inputs;

  assign unused_burst_inputs = start_i ^ (^burst_len_i);
  assign allow  = 1'b1;
  assign busy_o = 1'b0;
  assign done_o = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: a behavioural fifo feeds the read port, each scenario task
// checks its own hand-derived expectations.
module tb_fifo_rd_stream;
  localparam int DW    = 4;
  localparam int CNT_W = 8;

  logic             rclk        = 1'b0;
  logic             rst_ni      = 1'b0;
  logic             empty;
  logic [DW-1:0]    dat_i       = '0;
  logic             ren;
  logic [DW-1:0]    m_dat_o;
  logic             m_vld_o;
  logic             m_rdy_i     = 1'b0;
  logic [CNT_W-1:0] cnt_o;
  logic             start_i     = 1'b0;
  logic [CNT_W-1:0] burst_len_i = '0;
  logic             busy_o;
  logic             done_o;

  logic [DW-1:0]    fifo_mem [0:1023];
  int               wr_ptr     = 0;
  int               rd_ptr     = 0;
  logic             hold_empty = 1'b0;
  logic [DW-1:0]    exp_q[$];
  logic [CNT_W-1:0] cnt_exp    = '0;
  int               n_pass     = 0;
  int               n_total    = 0;

  fifo_rd_stream #(.DW(DW), .CNT_W(CNT_W)) dut (
    .rclk(rclk), .rst_ni(rst_ni), .empty(empty), .dat_i(dat_i), .ren(ren),
    .m_dat_o(m_dat_o), .m_vld_o(m_vld_o), .m_rdy_i(m_rdy_i), .cnt_o(cnt_o),
    .start_i(start_i), .burst_len_i(burst_len_i), .busy_o(busy_o), .done_o(done_o)
  );

  // clock / fifo model
  always #5 rclk = ~rclk;

  assign empty = (wr_ptr == rd_ptr) || hold_empty;

  always @(posedge rclk) begin
    if (ren) begin
      dat_i  <= fifo_mem[rd_ptr];
      exp_q.push_back(fifo_mem[rd_ptr]);
      rd_ptr <= rd_ptr + 1;
    end
  end

  task automatic push(input logic [DW-1:0] d);
    fifo_mem[wr_ptr] = d;
    wr_ptr++;
  endtask

  task automatic test_reset;
    rst_ni  = 1'b0;
    m_rdy_i = 1'b1;
    for (int i = 1; i <= 4; i++) push(DW'(i));
    @(negedge rclk);
    @(negedge rclk);
    #1;
    n_total++; if (ren !== 1'b0) $display("FAIL reset_ren: got %b want 0", ren); else n_pass++;
    n_total++; if (m_vld_o !== 1'b0) $display("FAIL reset_vld: got %b want 0", m_vld_o); else n_pass++;
    n_total++; if (m_dat_o !== 4'h0) $display("FAIL reset_dat: got %h want 0", m_dat_o); else n_pass++;
    n_total++; if (cnt_o !== 8'd0) $display("FAIL reset_cnt: got %0d want 0", cnt_o); else n_pass++;
    n_total++; if ({busy_o, done_o} !== 2'b00) $display("FAIL reset_busy_done: got %b want 00", {busy_o, done_o}); else n_pass++;
    rst_ni = 1'b1;
    #1;
`ifdef FIFO_RD_BURST_EN
    n_total++; if (ren !== 1'b0) $display("FAIL release_ren_idle: got %b want 0", ren); else n_pass++;
`else
    n_total++; if (ren !== 1'b1) $display("FAIL release_ren: got %b want 1", ren); else n_pass++;
`endif
  endtask

  task automatic test_streaming;
    @(negedge rclk); #1;
    n_total++; if (m_vld_o !== 1'b0) $display("FAIL stream_latency: vld got %b want 0", m_vld_o); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      @(negedge rclk); #1;
      n_total++;
      if (m_vld_o !== 1'b1 || m_dat_o !== DW'(i + 1))
        $display("FAIL stream_word%0d: got vld=%b dat=%h want vld=1 dat=%h", i, m_vld_o, m_dat_o, DW'(i + 1));
      else n_pass++;
      if (i == 2) begin
        n_total++; if (ren !== 1'b0) $display("FAIL stream_empty_ren: got %b want 0", ren); else n_pass++;
      end
    end
    @(negedge rclk); #1;
    cnt_exp = 8'd4;
    n_total++; if (m_vld_o !== 1'b0) $display("FAIL stream_tail_vld: got %b want 0", m_vld_o); else n_pass++;
    n_total++; if (cnt_o !== cnt_exp) $display("FAIL stream_cnt: got %0d want %0d", cnt_o, cnt_exp); else n_pass++;
  endtask

  task automatic test_backpressure;
    int ren_cnt = 0;
    exp_q.delete();
    m_rdy_i = 1'b0;
    for (int i = 5; i <= 9; i++) push(DW'(i));
    #1;
    for (int c = 0; c < 6; c++) begin
      if (ren) ren_cnt++;
      @(negedge rclk); #1;
    end
    n_total++; if (ren_cnt != 2) $display("FAIL bp_ren_pulses: got %0d want 2", ren_cnt); else n_pass++;
    n_total++; if (exp_q.size() != 2) $display("FAIL bp_occupancy: got %0d want 2", exp_q.size()); else n_pass++;
    n_total++; if (m_vld_o !== 1'b1 || m_dat_o !== 4'h5) $display("FAIL bp_hold: got vld=%b dat=%h want vld=1 dat=5", m_vld_o, m_dat_o); else n_pass++;
    m_rdy_i = 1'b1;
    for (int w = 6; w <= 9; w++) begin
      @(negedge rclk); #1;
      n_total++;
      if (m_vld_o !== 1'b1 || m_dat_o !== DW'(w))
        $display("FAIL bp_release_word: got vld=%b dat=%h want vld=1 dat=%h", m_vld_o, m_dat_o, DW'(w));
      else n_pass++;
    end
    @(negedge rclk); #1;
    cnt_exp = 8'd9;
    n_total++; if (m_vld_o !== 1'b0) $display("FAIL bp_tail_vld: got %b want 0", m_vld_o); else n_pass++;
    n_total++; if (cnt_o !== cnt_exp) $display("FAIL bp_cnt: got %0d want %0d", cnt_o, cnt_exp); else n_pass++;
  endtask

  task automatic test_random_stall;
    int xfers = 0;
    bit drained = 1'b0;
    logic [DW-1:0] want;
    exp_q.delete();
    for (int c = 0; c < 1060; c++) begin
      @(negedge rclk);
      if (c < 1000) begin
        m_rdy_i    = 1'($urandom_range(0, 1));
        hold_empty = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 1) == 1) push(DW'($urandom_range(0, 15)));
      end else begin
        m_rdy_i    = 1'b1;
        hold_empty = 1'b0;
      end
      #1;
      if (c >= 1000 && wr_ptr == rd_ptr && exp_q.size() == 0 && !m_vld_o) begin
        drained = 1'b1;
        break;
      end
      n_total++; if (exp_q.size() > 2) $display("FAIL rnd_credit: outstanding %0d want <=2", exp_q.size()); else n_pass++;
      n_total++; if (ren && empty) $display("FAIL rnd_ren_empty: ren=%b empty=%b", ren, empty); else n_pass++;
      if (m_vld_o && m_rdy_i) begin
        n_total++;
        if (exp_q.size() == 0) $display("FAIL rnd_extra_word: got dat=%h want no word", m_dat_o);
        else begin
          want = exp_q.pop_front();
          if (m_dat_o !== want) $display("FAIL rnd_order: got %h want %h", m_dat_o, want);
          else n_pass++;
        end
        xfers++;
      end
    end
    n_total++; if (!drained) $display("FAIL rnd_drain_timeout: left %0d want 0", exp_q.size()); else n_pass++;
    cnt_exp = cnt_exp + CNT_W'(xfers);
    n_total++; if (cnt_o !== cnt_exp) $display("FAIL rnd_cnt_wrap: got %0d want %0d", cnt_o, cnt_exp); else n_pass++;
  endtask

  task automatic test_reset_mid;
    m_rdy_i = 1'b0;
    for (int i = 10; i <= 13; i++) push(DW'(i));
    @(negedge rclk);
    @(negedge rclk); #1;
    n_total++; if (m_vld_o !== 1'b1 || m_dat_o !== 4'hA) $display("FAIL mid_pre: got vld=%b dat=%h want vld=1 dat=a", m_vld_o, m_dat_o); else n_pass++;
    rst_ni = 1'b0;
    #1;
    n_total++; if ({ren, m_vld_o} !== 2'b00) $display("FAIL mid_async_ctl: got %b want 00", {ren, m_vld_o}); else n_pass++;
    n_total++; if (m_dat_o !== 4'h0) $display("FAIL mid_async_dat: got %h want 0", m_dat_o); else n_pass++;
    n_total++; if (cnt_o !== 8'd0) $display("FAIL mid_async_cnt: got %0d want 0", cnt_o); else n_pass++;
    exp_q.delete();
    @(negedge rclk);
    rst_ni  = 1'b1;
    m_rdy_i = 1'b1;
    @(negedge rclk); #1;
    n_total++; if (m_vld_o !== 1'b0) $display("FAIL mid_latency: vld got %b want 0", m_vld_o); else n_pass++;
    for (int w = 12; w <= 13; w++) begin
      @(negedge rclk); #1;
      n_total++;
      if (m_vld_o !== 1'b1 || m_dat_o !== DW'(w))
        $display("FAIL mid_word: got vld=%b dat=%h want vld=1 dat=%h", m_vld_o, m_dat_o, DW'(w));
      else n_pass++;
    end
    @(negedge rclk); #1;
    cnt_exp = 8'd2;
    n_total++; if (cnt_o !== cnt_exp) $display("FAIL mid_cnt: got %0d want %0d", cnt_o, cnt_exp); else n_pass++;
  endtask

  task automatic test_start_ignored;
    int flag_hits = 0;
    m_rdy_i     = 1'b1;
    start_i     = 1'b1;
    burst_len_i = 8'd3;
    push(4'h5);
    push(4'h6);
    for (int c = 0; c < 6; c++) begin
      @(negedge rclk); #1;
      start_i = 1'b0;
      if (busy_o !== 1'b0 || done_o !== 1'b0) flag_hits++;
    end
    cnt_exp = cnt_exp + 8'd2;
    n_total++; if (flag_hits != 0) $display("FAIL freerun_flags: busy/done seen %0d times want 0", flag_hits); else n_pass++;
    n_total++; if (cnt_o !== cnt_exp) $display("FAIL freerun_cnt: got %0d want %0d", cnt_o, cnt_exp); else n_pass++;
  endtask

  task automatic test_burst;
    int ren_cnt = 0;
    int xfers   = 0;
    int dones   = 0;
    int rd_before;
    m_rdy_i = 1'b1;
    push(4'h5);
    @(negedge rclk);
    start_i     = 1'b1;
    burst_len_i = 8'd3;
    #1;
    for (int c = 0; c < 20; c++) begin
      @(negedge rclk);
      start_i = 1'b0;
      #1;
      if (ren) ren_cnt++;
      if (done_o) dones++;
      if (m_vld_o && m_rdy_i) begin
        xfers++;
        n_total++;
        if (m_dat_o !== DW'(xfers)) $display("FAIL burst_word: got %h want %h", m_dat_o, DW'(xfers));
        else n_pass++;
      end
    end
    n_total++; if (ren_cnt != 3) $display("FAIL burst_ren: got %0d want 3", ren_cnt); else n_pass++;
    n_total++; if (xfers != 3) $display("FAIL burst_xfers: got %0d want 3", xfers); else n_pass++;
    n_total++; if (dones != 1) $display("FAIL burst_done: got %0d pulses want 1", dones); else n_pass++;
    n_total++; if (busy_o !== 1'b0) $display("FAIL burst_busy: got %b want 0", busy_o); else n_pass++;
    n_total++; if (wr_ptr - rd_ptr != 2) $display("FAIL burst_left: got %0d want 2", wr_ptr - rd_ptr); else n_pass++;
    rd_before = rd_ptr;
    dones = 0;
    start_i     = 1'b1;
    burst_len_i = 8'd0;
    for (int c = 0; c < 4; c++) begin
      @(negedge rclk);
      start_i = 1'b0;
      #1;
      if (done_o) dones++;
    end
    n_total++; if (dones != 1) $display("FAIL burst_zero_done: got %0d pulses want 1", dones); else n_pass++;
    n_total++; if (rd_ptr != rd_before) $display("FAIL burst_zero_ren: popped %0d want 0", rd_ptr - rd_before); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
`ifdef FIFO_RD_BURST_EN
    test_burst();
`else
    test_streaming();
    test_backpressure();
    test_random_stall();
    test_reset_mid();
    test_start_ignored();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
